// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;  // register / data width
   localparam int NREGS_DEF  = 16;  // architectural register count
   localparam int NRD_DEF    = 2;   // number of read ports
   localparam int PC_OFS_DEF = 8;   // offset added to pc on a PC-index read

   // Address width for a register count; never zero so a 1-entry file still
   // has a legal address port.
   function automatic int addr_w(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks an outstanding producer.
// Latency: issue/writeback/flush take effect on the next rising edge.
// Backpressure: none; every issue, writeback and flush is accepted each cycle.
//
// Ports:
//   clk, rst        clock, async active-high reset (clears all busy bits)
//   iss_v, iss_a    issue of an instruction that will later write iss_a
//   we, wa          writeback that retires the producer of wa
//   flush           discard all outstanding producers
//   busy            current busy bits
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int PC_IDX = NREGS_DEF - 1,
   localparam int AW    = addr_w(NREGS)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_v,
   input  logic [AW-1:0]    iss_a,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic             flush,
   output logic [NREGS-1:0] busy
);

   logic             set_ok;
   logic             clr_ok;
   logic [NREGS-1:0] busy_nxt;

   // The PC index never has a producer, so issuing to it is ignored.
   // Out-of-range addresses change nothing.
   assign set_ok = iss_v && (int'(iss_a) < NREGS) && (int'(iss_a) != PC_IDX);
   assign clr_ok = we && (int'(wa) < NREGS);

   always_comb begin
      busy_nxt = busy;
      if (flush) begin
         // Flush overrides any same-cycle issue.
         busy_nxt = '0;
      end else begin
         // Clear first, then set: a new producer issued to the register
         // that is being written back this cycle keeps the bit high.
         if (clr_ok) begin
            busy_nxt[wa] = 1'b0;
         end
         if (set_ok) begin
            busy_nxt[iss_a] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass, PC read alias and scoreboard.
// Latency: reads combinational (0 cycles); writes and busy updates visible after next edge.
// Backpressure: none; rd_busy flags reads whose producer has not yet written back.
//
// Ports:
//   clk, rst        clock, async active-high reset (storage and busy cleared)
//   ra / rd         NRD packed read addresses / read data (port k = slice k)
//   rd_busy         per read port: value not yet produced
//   pc              current program counter (read at PC_IDX as pc + PC_OFS)
//   we, wa, wd      writeback enable, address, data
//   iss_v, iss_a    issue of a future producer of iss_a
//   flush           drop all outstanding producers
//   busy_vec        current scoreboard bits
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = NRD_DEF,
   parameter int PC_IDX = NREGS - 1,
   parameter int PC_OFS = PC_OFS_DEF,
   localparam int AW    = addr_w(NREGS)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*AW-1:0]     ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        rd_busy,
   input  logic [DATA_W-1:0]     pc,
   input  logic                  we,
   input  logic [AW-1:0]         wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic                  iss_v,
   input  logic [AW-1:0]         iss_a,
   input  logic                  flush,
   output logic [NREGS-1:0]      busy_vec
);

   logic [DATA_W-1:0] mem [NREGS];
   logic              wr_ok;
   logic [DATA_W-1:0] pc_val;

   // Writes to the PC alias slot or beyond the file are dropped.
   assign wr_ok  = we && (int'(wa) < NREGS) && (int'(wa) != PC_IDX);
   assign pc_val = pc + DATA_W'(PC_OFS);

   // ------------------------------------------------------------------
   // Storage: the only place storage is written.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wa] <= wd;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   regfile_scoreboard #(
      .NREGS  (NREGS),
      .PC_IDX (PC_IDX)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .iss_v  (iss_v),
      .iss_a  (iss_a),
      .we     (we),
      .wa     (wa),
      .flush  (flush),
      .busy   (busy_vec)
   );

   // ------------------------------------------------------------------
   // Read ports: PC alias > write-first bypass > storage.
   // ------------------------------------------------------------------
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]     a;
      logic              in_rng;
      logic              hit_pc;
      logic              hit_byp;
      logic [DATA_W-1:0] dat;

      assign a       = ra[k*AW +: AW];
      assign in_rng  = int'(a) < NREGS;
      assign hit_pc  = int'(a) == PC_IDX;
      // Writes are ignored while in reset, so the bypass is too; this keeps
      // every non-PC read at zero during reset.
      assign hit_byp = !rst && we && (wa == a);

      always_comb begin
         dat = '0;
         if (hit_pc) begin
            dat = pc_val;
         end else if (hit_byp) begin
            dat = wd;
         end else if (in_rng) begin
            dat = mem[a];
         end
      end

      assign rd[k*DATA_W +: DATA_W] = dat;
      // A value arriving through the bypass is already produced.
      assign rd_busy[k] = in_rng && !hit_pc && !hit_byp && busy_vec[a];
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int NR = 16;
   localparam int ND = 2;
   localparam int AW = 4;

   logic             clk;
   logic             rst;
   logic [ND*AW-1:0] ra;
   logic [ND*DW-1:0] rd;
   logic [ND-1:0]    rd_busy;
   logic [DW-1:0]    pc;
   logic             we;
   logic [AW-1:0]    wa;
   logic [DW-1:0]    wd;
   logic             iss_v;
   logic [AW-1:0]    iss_a;
   logic             flush;
   logic [NR-1:0]    busy_vec;

   regfile_mp #(
      .DATA_W (DW),
      .NREGS  (NR),
      .NRD    (ND),
      .PC_IDX (15),
      .PC_OFS (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ra       (ra),
      .rd       (rd),
      .rd_busy  (rd_busy),
      .pc       (pc),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .iss_v    (iss_v),
      .iss_a    (iss_a),
      .flush    (flush),
      .busy_vec (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] ra0, ra1;
      logic [DW-1:0] pc;
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          iv;
      logic [AW-1:0] ia;
      logic          fl;
      logic [DW-1:0] e_rd0, e_rd1;
      logic          e_b0, e_b1;
      logic [NR-1:0] e_busy;   // busy_vec expected after the edge
   } vec_t;

   vec_t tbl [18];
   vec_t exp_q [$];
   int   n_pass = 0;
   int   n_tot  = 0;

   function automatic vec_t mk(input logic [AW-1:0] ra0, ra1, input logic [DW-1:0] pcv,
                               input logic wev, input logic [AW-1:0] wav, input logic [DW-1:0] wdv,
                               input logic iv, input logic [AW-1:0] ia, input logic fl,
                               input logic [DW-1:0] e0, e1, input logic b0, b1,
                               input logic [NR-1:0] eb);
      vec_t v;
      v.ra0 = ra0; v.ra1 = ra1; v.pc = pcv; v.we = wev; v.wa = wav; v.wd = wdv;
      v.iv = iv; v.ia = ia; v.fl = fl;
      v.e_rd0 = e0; v.e_rd1 = e1; v.e_b0 = b0; v.e_b1 = b1; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input vec_t v);
      ra    = {v.ra1, v.ra0};
      pc    = v.pc;
      we    = v.we;
      wa    = v.wa;
      wd    = v.wd;
      iss_v = v.iv;
      iss_a = v.ia;
      flush = v.fl;
      exp_q.push_back(v);
   endtask

   task automatic idle();
      we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0; flush = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t e;
      // ---------------- vector table (state carries between rows) ----------------
      tbl[0]  = mk(3, 15, 'h100, 1, 3, 'hDEADBEEF, 0, 0, 0, 'hDEADBEEF, 'h108, 0, 0, 'h0000);
      tbl[1]  = mk(3, 3,  'h200, 0, 0, 0,          0, 0, 0, 'hDEADBEEF, 'hDEADBEEF, 0, 0, 'h0000);
      tbl[2]  = mk(5, 5,  'h200, 0, 0, 0,          1, 5, 0, 0, 0, 0, 0, 'h0020);
      tbl[3]  = mk(3, 5,  'h200, 0, 0, 0,          0, 0, 0, 'hDEADBEEF, 0, 0, 1, 'h0020);
      tbl[4]  = mk(5, 5,  'h200, 1, 5, 7,          0, 0, 0, 7, 7, 0, 0, 'h0000);
      tbl[5]  = mk(5, 0,  'h200, 0, 0, 0,          0, 0, 0, 7, 0, 0, 0, 'h0000);
      tbl[6]  = mk(4, 3,  'h200, 1, 4, 'h44,       1, 4, 0, 'h44, 'hDEADBEEF, 0, 0, 'h0010);
      tbl[7]  = mk(4, 4,  'h200, 0, 0, 0,          0, 0, 0, 'h44, 'h44, 1, 1, 'h0010);
      tbl[8]  = mk(1, 4,  'h200, 0, 0, 0,          1, 1, 0, 0, 'h44, 0, 1, 'h0012);
      tbl[9]  = mk(2, 1,  'h200, 0, 0, 0,          1, 2, 0, 0, 0, 0, 1, 'h0016);
      tbl[10] = mk(6, 2,  'h200, 0, 0, 0,          1, 6, 0, 0, 0, 0, 1, 'h0056);
      tbl[11] = mk(15, 4, 'h300, 1, 15, 'h1234,    1, 9, 1, 'h308, 'h44, 0, 1, 'h0000);
      tbl[12] = mk(15, 9, 'h300, 0, 0, 0,          0, 0, 0, 'h308, 0, 0, 0, 'h0000);
      tbl[13] = mk(4, 15, 'h10,  0, 0, 0,          1, 15, 0, 'h44, 'h18, 0, 0, 'h0000);
      tbl[14] = mk(8, 4,  'h0,   1, 8, 'h88,       0, 0, 1, 'h88, 'h44, 0, 0, 'h0000);
      tbl[15] = mk(8, 15, 'hFFFFFFFC, 0, 0, 0,     0, 0, 0, 'h88, 'h4, 0, 0, 'h0000);
      tbl[16] = mk(3, 7,  'h0,   1, 3, 'h33,       1, 7, 0, 'h33, 0, 0, 0, 'h0080);
      tbl[17] = mk(7, 7,  'h0,   1, 7, 'h77,       0, 0, 0, 'h77, 'h77, 0, 0, 'h0000);

      // ---------------- reset ----------------
      rst = 1'b1;
      idle();
      ra = {4'd15, 4'd3};
      pc = 'h100;
      #2;
      chk("reset_busy_vec", 64'(busy_vec), 64'h0);
      chk("reset_rd0", 64'(rd[DW-1:0]), 64'h0);
      chk("reset_rd1_pc", 64'(rd[2*DW-1:DW]), 64'h108);
      chk("reset_rd_busy", 64'(rd_busy), 64'h0);
      // A write attempted during reset must not land or bypass.
      we = 1'b1; wa = 4'd3; wd = 'h55;
      #1;
      chk("reset_no_bypass", 64'(rd[DW-1:0]), 64'h0);
      @(posedge clk); #1;
      chk("reset_write_ignored", 64'(rd[DW-1:0]), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i]);
         #2;
         e = exp_q.pop_front();
         chk($sformatf("v%0d_rd0", i), 64'(rd[DW-1:0]), 64'(e.e_rd0));
         chk($sformatf("v%0d_rd1", i), 64'(rd[2*DW-1:DW]), 64'(e.e_rd1));
         chk($sformatf("v%0d_rd_busy0", i), 64'(rd_busy[0]), 64'(e.e_b0));
         chk($sformatf("v%0d_rd_busy1", i), 64'(rd_busy[1]), 64'(e.e_b1));
         @(posedge clk); #1;
         chk($sformatf("v%0d_busy_vec", i), 64'(busy_vec), 64'(e.e_busy));
         @(negedge clk);
      end
      idle();

      // ---------------- asynchronous reset pulse mid-run ----------------
      iss_v = 1'b1; iss_a = 4'd2;
      @(posedge clk); #1;
      chk("pre_rst_busy", 64'(busy_vec), 64'h0004);
      idle();
      ra = {4'd15, 4'd3};
      pc = 'h100;
      #2;
      chk("pre_rst_rd0", 64'(rd[DW-1:0]), 64'h33);
      rst = 1'b1;          // asserted between edges
      #1;
      chk("midrst_busy_vec", 64'(busy_vec), 64'h0);
      chk("midrst_rd0", 64'(rd[DW-1:0]), 64'h0);
      chk("midrst_rd1_pc", 64'(rd[2*DW-1:DW]), 64'h108);
      chk("midrst_rd_busy", 64'(rd_busy), 64'h0);
      iss_v = 1'b1; iss_a = 4'd6; flush = 1'b0;
      @(posedge clk); #1;
      chk("midrst_issue_ignored", 64'(busy_vec), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      ra = {4'd8, 4'd7};
      #2;
      chk("post_rst_rd0", 64'(rd[DW-1:0]), 64'h0);
      chk("post_rst_rd1", 64'(rd[2*DW-1:DW]), 64'h0);
      // Normal operation resumes on the first edge after release.
      we = 1'b1; wa = 4'd8; wd = 'hCAFE;
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      chk("post_rst_write", 64'(rd[2*DW-1:DW]), 64'hCAFE);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
